// File: rtl/i2s_clkgen.sv
// ----------------------------------------------------------------------------
// i2s_clkgen: I2S bit-clock divider.
// Divides clk down to sck and flags the clk cycle whose edge drives sck 1->0,
// so serialisers can update their outputs on that same edge.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   sck_o   bit clock, registered, period 2*div clk cycles, low out of reset
//   fall_o  one-clk strobe, high in the cycle whose closing edge drops sck
// ----------------------------------------------------------------------------
module i2s_clkgen #(
   parameter int div = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic sck_o,
   output logic fall_o
);

   localparam int CW = (div > 1) ? $clog2(div) : 1;
   localparam logic [CW-1:0] TC = CW'(div - 1);

   logic [CW-1:0] cnt_q;
   logic          sck_q;
   logic          tc;

   assign tc = (cnt_q == TC);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (tc) begin
         cnt_q <= '0;
         sck_q <= ~sck_q;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign sck_o  = sck_q;
   // Terminal count while sck is high: the coming edge is the fall event.
   assign fall_o = tc & sck_q;

endmodule

// File: rtl/i2s_tx.sv
// ----------------------------------------------------------------------------
// i2s_tx: Philips I2S master transmitter.
// Generates sck/ws and shifts a left/right pair MSB first, data lagging ws
// by one slot. ws, sd and ock all change on the clk edge that drops sck.
//   clk  system clock
//   rst  asynchronous active-high reset
//   l    left sample  (b bits), captured entering slot 0
//   r    right sample (b bits), captured entering slot 0
//   sck  bit clock
//   ws   word select, 0 = left, 1 = right
//   sd   serial data
//   ock  one-clk pulse after the l/r capture edge (request for next pair)
// ----------------------------------------------------------------------------
module i2s_tx #(
   parameter int b   = 16,
   parameter int div = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [b-1:0] l,
   input  logic [b-1:0] r,
   output logic         sck,
   output logic         ws,
   output logic         sd,
   output logic         ock
);

   localparam int SW = $clog2(2 * b);
   localparam logic [SW-1:0] SLAST = SW'(2 * b - 1);
   localparam logic [SW-1:0] WS_LO = SW'(b - 1);
   localparam logic [SW-1:0] WS_HI = SW'(2 * b - 2);

   logic            fall;
   logic [SW-1:0]   s_q, s_d;
   logic [2*b-1:0]  sh_q, sh_d;
   logic            ws_q, ws_d;
   logic            sd_q;
   logic            ock_q;
   logic            wrap;

   i2s_clkgen #(.div(div)) u_clkgen (
      .clk_i  (clk),
      .rst_i  (rst),
      .sck_o  (sck),
      .fall_o (fall)
   );

   always_comb begin
      wrap = (s_q == SLAST);
      s_d  = wrap ? '0 : s_q + SW'(1);
      // ws leads the channel data by one slot, hence the b-1 .. 2b-2 window.
      ws_d = (s_d >= WS_LO) && (s_d <= WS_HI);
      // The register top bit always holds the bit due next; after 2b-1 shifts
      // it is r[0], which goes out in slot 0 alongside the new capture.
      sh_d = wrap ? {l, r} : {sh_q[2*b-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q   <= SLAST;
         sh_q  <= '0;
         ws_q  <= 1'b0;
         sd_q  <= 1'b0;
         ock_q <= 1'b0;
      end else begin
         ock_q <= fall & wrap;
         if (fall) begin
            s_q  <= s_d;
            sh_q <= sh_d;
            ws_q <= ws_d;
            sd_q <= sh_q[2*b-1];
         end
      end
   end

   assign ws  = ws_q;
   assign sd  = sd_q;
   assign ock = ock_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
   localparam int B = 5;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [B-1:0] l = '0, r = '0;
   logic sck, ws, sd, ock;

   logic rst1 = 1'b1;
   logic [1:0] l1 = 2'b10, r1 = 2'b01;
   logic sck1, ws1, sd1, ock1;

   always #5 clk = ~clk;

   i2s_tx #(.b(B), .div(D)) dut (
      .clk(clk), .rst(rst), .l(l), .r(r),
      .sck(sck), .ws(ws), .sd(sd), .ock(ock));

   i2s_tx #(.b(2), .div(1)) dut1 (
      .clk(clk), .rst(rst1), .l(l1), .r(r1),
      .sck(sck1), .ws(ws1), .sd(sd1), .ock(ock1));

   typedef struct packed {logic sd; logic ws; logic ock;} exp_t;
   exp_t q[$];
   exp_t q1[$];

   int   nvec = 0, nerr = 0;
   int   cyc = 0, t_ock = 0;
   logic last = 1'b0;
   logic prev_r0 = 1'b0;

   task automatic chk1(input string tag, input logic obs, input logic expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Expected slot table for one frame, built from the slot definitions.
   task automatic push_frame(input logic [B-1:0] fl, input logic [B-1:0] fr);
      exp_t e;
      for (int s = 0; s < 2*B; s++) begin
         e.ock = (s == 0);
         e.ws  = (s >= B-1) && (s <= 2*B-2);
         if (s == 0)      e.sd = prev_r0;
         else if (s <= B) e.sd = fl[B-s];
         else             e.sd = fr[2*B-s];
         q.push_back(e);
      end
      prev_r0 = fr[0];
   endtask

   task automatic wait_fall(input string tag);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         tick();
         if (last && !sck) found = 1'b1;
         last = sck;
      end
      chk1({tag, "_fall"}, found, 1'b1);
   endtask

   task automatic check_slot(input string tag);
      exp_t e;
      chk1({tag, "_sb"}, q.size() > 0, 1'b1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk1({tag, "_sd"},  sd,  e.sd);
         chk1({tag, "_ws"},  ws,  e.ws);
         chk1({tag, "_ock"}, ock, e.ock);
         tick();
         last = sck;
         chk1({tag, "_ockdrop"}, ock, 1'b0);
      end
   endtask

   // Release reset just after a negedge and check sck edge timing up to the
   // first fall event, which is slot 0 of the first frame.
   task automatic release_check(input string tag);
      rst = 1'b0;
      tick(); chk1({tag, "_c1_sck"}, sck, 1'b0);
      tick(); chk1({tag, "_c2_sck"}, sck, 1'b1);
      tick(); chk1({tag, "_c3_sck"}, sck, 1'b1);
      tick(); chk1({tag, "_c4_sck"}, sck, 1'b0);
      last  = 1'b0;
      t_ock = cyc;
      check_slot({tag, "_s0"});
   endtask

   initial begin
      logic [4:0] sdx, wsx;
      exp_t e;

      l = 5'b10110;
      r = 5'b01001;
      repeat (3) tick();
      chk1("rst_sck", sck, 1'b0);
      chk1("rst_ws",  ws,  1'b0);
      chk1("rst_sd",  sd,  1'b0);
      chk1("rst_ock", ock, 1'b0);

      // Frame 1: pattern l=10110 r=01001
      push_frame(l, r);
      release_check("rel");
      for (int s = 1; s < 2*B; s++) begin
         wait_fall($sformatf("f1_s%0d", s));
         check_slot($sformatf("f1_s%0d", s));
      end

      // Frame 2: same pair; l cleared mid-frame must not disturb it
      push_frame(l, r);
      for (int s = 0; s < 2*B; s++) begin
         wait_fall($sformatf("f2_s%0d", s));
         if (s == 0) begin
            chki("f2_period", cyc - t_ock, 40);
            t_ock = cyc;
         end
         check_slot($sformatf("f2_s%0d", s));
         if (s == 3) begin
            l = 5'b00000;
            push_frame(l, r);
         end
      end

      // Frame 3: l=00000 captured; load next pair early in the frame
      for (int s = 0; s < 2*B; s++) begin
         wait_fall($sformatf("f3_s%0d", s));
         if (s == 0) begin
            chki("f3_period", cyc - t_ock, 40);
            t_ock = cyc;
         end
         check_slot($sformatf("f3_s%0d", s));
         if (s == 1) begin
            l = 5'b11001;
            r = 5'b00111;
            push_frame(l, r);
         end
      end

      // Frame 4 up to slot 6, then asynchronous reset while sck is high
      for (int s = 0; s <= 6; s++) begin
         wait_fall($sformatf("f4_s%0d", s));
         check_slot($sformatf("f4_s%0d", s));
      end
      for (int n = 0; n < 8 && sck !== 1'b1; n++) tick();
      chk1("prerst_sck", sck, 1'b1);
      chk1("prerst_ws",  ws,  1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("midrst_sck", sck, 1'b0);
      chk1("midrst_ws",  ws,  1'b0);
      chk1("midrst_sd",  sd,  1'b0);
      chk1("midrst_ock", ock, 1'b0);

      q.delete();
      prev_r0 = 1'b0;
      push_frame(l, r);
      repeat (2) tick();
      release_check("rel2");
      for (int s = 1; s < 2*B; s++) begin
         wait_fall($sformatf("f5_s%0d", s));
         check_slot($sformatf("f5_s%0d", s));
      end

      // div=1, b=2: sck toggles every clk, frame is 8 clk
      sdx = 5'b10010;   // slots 0,1,2,3,0 -> bit k = slot k
      wsx = 5'b00110;
      for (int k = 0; k < 5; k++) begin
         e.sd  = sdx[k];
         e.ws  = wsx[k];
         e.ock = (k % 4 == 0);
         q1.push_back(e);
      end
      rst1 = 1'b0;
      for (int ed = 1; ed <= 10; ed++) begin
         tick();
         if (ed % 2 == 1) begin
            chk1($sformatf("d1_e%0d_sck", ed), sck1, 1'b1);
            chk1($sformatf("d1_e%0d_ock", ed), ock1, 1'b0);
         end else begin
            chk1($sformatf("d1_e%0d_sck", ed), sck1, 1'b0);
            if (q1.size() > 0) begin
               e = q1.pop_front();
               chk1($sformatf("d1_e%0d_sd",  ed), sd1,  e.sd);
               chk1($sformatf("d1_e%0d_ws",  ed), ws1,  e.ws);
               chk1($sformatf("d1_e%0d_ock", ed), ock1, e.ock);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
